// File: rtl/spdif_pkg.sv
// Shared types, default limits and the threshold calculation for the S/PDIF lock controller.
package spdif_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StMeasure = 3'd1,
        StCalc    = 3'd2,
        StAcquire = 3'd3,
        StLocked  = 3'd4,
        StHoldoff = 3'd5
    } lock_state_e;

    localparam int unsigned WinEdgesDef    = 256;
    localparam int unsigned MinUiDef       = 3;
    localparam int unsigned MaxUiDef       = 63;
    localparam int unsigned SyncNeedDef    = 4;
    localparam int unsigned AcqTimeoutDef  = 65535;
    localparam int unsigned SyncTimeoutDef = 4095;
    localparam int unsigned ErrMaxDef      = 8;
    localparam int unsigned HoldoffDef     = 1023;

    typedef struct packed {
        logic [7:0] thr_short;
        logic [7:0] thr_long;
    } thr_t;

    // Short/long boundaries sit halfway between 1/2 UI and 2/3 UI; saturate at 255.
    function automatic thr_t calc_thr(input logic [7:0] ui);
        logic [9:0] s;
        logic [9:0] l;
        thr_t       t;
        s = {2'b00, ui} + {3'b000, ui[7:1]};
        l = {1'b0, ui, 1'b0} + {3'b000, ui[7:1]};
        t.thr_short = (s > 10'd255) ? 8'hFF : s[7:0];
        t.thr_long  = (l > 10'd255) ? 8'hFF : l[7:0];
        return t;
    endfunction

endpackage

// File: rtl/spdif_ui_estimator.sv
// Counts non-glitch edges over one measurement window and tracks the shortest edge length seen.
module spdif_ui_estimator #(
    parameter int unsigned WinEdges = 256
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       run,
    input  logic       edge_valid,
    input  logic [7:0] edge_len,
    output logic       done,
    output logic [7:0] min_len
);

    localparam int unsigned CntW = $clog2(WinEdges + 1);

    logic [CntW-1:0] edge_cnt_q, edge_cnt_d;
    logic [7:0]      min_len_q, min_len_d;

    assign done    = (edge_cnt_q == CntW'(WinEdges));
    assign min_len = min_len_q;

    // Window state is held clear whenever the controller is not measuring.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        min_len_d  = min_len_q;
        if (!run) begin
            edge_cnt_d = '0;
            min_len_d  = 8'hFF;
        end else if (edge_valid && (edge_len >= 8'd2) && !done) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
            if (edge_len < min_len_q) begin
                min_len_d = edge_len;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            edge_cnt_q <= '0;
            min_len_q  <= 8'hFF;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            min_len_q  <= min_len_d;
        end
    end

endmodule

// File: rtl/spdif_lock_ctrl.sv
// Acquisition/lock FSM: measures the UI, programs decode thresholds, tracks preamble lock.
module spdif_lock_ctrl
    import spdif_pkg::*;
#(
    parameter int unsigned WinEdges    = WinEdgesDef,
    parameter int unsigned MinUi       = MinUiDef,
    parameter int unsigned MaxUi       = MaxUiDef,
    parameter int unsigned SyncNeed    = SyncNeedDef,
    parameter int unsigned AcqTimeout  = AcqTimeoutDef,
    parameter int unsigned SyncTimeout = SyncTimeoutDef,
    parameter int unsigned ErrMax      = ErrMaxDef,
    parameter int unsigned Holdoff     = HoldoffDef
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable,
    input  logic       edge_valid,
    input  logic [7:0] edge_len,
    input  logic       frame_sync,
    input  logic       code_err,
    output logic [7:0] thr_short,
    output logic [7:0] thr_long,
    output logic [7:0] ui_len,
    output logic       dec_enable,
    output logic       dec_restart,
    output logic       audio_locked,
    output logic [2:0] lock_state,
    output logic [7:0] relock_cnt
);

    lock_state_e state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [7:0]  sync_cnt_q, sync_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  relock_cnt_q, relock_cnt_d;
    logic [7:0]  ui_len_q, ui_len_d;
    logic [7:0]  thr_short_q, thr_short_d;
    logic [7:0]  thr_long_q, thr_long_d;
    logic        audio_locked_q, audio_locked_d;
    logic        dec_enable_q, dec_enable_d;

    logic        est_done;
    logic [7:0]  est_min;
    logic        ui_ok;
    logic        state_change;
    thr_t        thr_calc;

    spdif_ui_estimator #(
        .WinEdges(WinEdges)
    ) u_ui_estimator (
        .clk       (clk),
        .resetb    (resetb),
        .run       (state_q == StMeasure),
        .edge_valid(edge_valid),
        .edge_len  (edge_len),
        .done      (est_done),
        .min_len   (est_min)
    );

    assign ui_ok    = (est_min >= 8'(MinUi)) && (est_min <= 8'(MaxUi));
    assign thr_calc = calc_thr(est_min);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (enable) state_d = StMeasure;
            StMeasure: if (est_done) state_d = StCalc;
            StCalc:    state_d = ui_ok ? StAcquire : StMeasure;
            StAcquire: begin
                if (sync_cnt_q == 8'(SyncNeed)) begin
                    state_d = StLocked;
                end else if (tmr_q == 16'(AcqTimeout)) begin
                    state_d = StMeasure;
                end
            end
            StLocked: begin
                if ((tmr_q == 16'(SyncTimeout)) || (err_cnt_q == 8'(ErrMax))) begin
                    state_d = StHoldoff;
                end
            end
            StHoldoff: if (tmr_q == 16'(Holdoff)) state_d = StMeasure;
            default:   state_d = StIdle;
        endcase
        if (!enable) begin
            state_d = StIdle;
        end
    end

    assign state_change = (state_d != state_q);

    always_comb begin
        tmr_d        = (tmr_q == 16'hFFFF) ? tmr_q : tmr_q + 16'd1;
        sync_cnt_d   = sync_cnt_q;
        err_cnt_d    = err_cnt_q;
        relock_cnt_d = relock_cnt_q;
        ui_len_d     = ui_len_q;
        thr_short_d  = thr_short_q;
        thr_long_d   = thr_long_q;

        if (state_change || ((state_q == StLocked) && frame_sync)) begin
            tmr_d = '0;
        end

        if (state_change || (state_q != StAcquire) || code_err) begin
            sync_cnt_d = '0;
        end else if (frame_sync && (sync_cnt_q != 8'hFF)) begin
            sync_cnt_d = sync_cnt_q + 8'd1;
        end

        // Leaky error count: a sync and an error in the same cycle cancel out.
        if (state_change || (state_q != StLocked)) begin
            err_cnt_d = '0;
        end else if (code_err && !frame_sync && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else if (frame_sync && !code_err && (err_cnt_q != 8'd0)) begin
            err_cnt_d = err_cnt_q - 8'd1;
        end

        if ((state_d == StHoldoff) && (state_q != StHoldoff) && (relock_cnt_q != 8'hFF)) begin
            relock_cnt_d = relock_cnt_q + 8'd1;
        end

        if ((state_q == StCalc) && enable && ui_ok) begin
            ui_len_d    = est_min;
            thr_short_d = thr_calc.thr_short;
            thr_long_d  = thr_calc.thr_long;
        end

        audio_locked_d = (state_d == StLocked);
        dec_enable_d   = (state_d == StAcquire) || (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q        <= StIdle;
            tmr_q          <= '0;
            sync_cnt_q     <= '0;
            err_cnt_q      <= '0;
            relock_cnt_q   <= '0;
            ui_len_q       <= '0;
            thr_short_q    <= '0;
            thr_long_q     <= '0;
            audio_locked_q <= 1'b0;
            dec_enable_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            sync_cnt_q     <= sync_cnt_d;
            err_cnt_q      <= err_cnt_d;
            relock_cnt_q   <= relock_cnt_d;
            ui_len_q       <= ui_len_d;
            thr_short_q    <= thr_short_d;
            thr_long_q     <= thr_long_d;
            audio_locked_q <= audio_locked_d;
            dec_enable_q   <= dec_enable_d;
        end
    end

    assign thr_short    = thr_short_q;
    assign thr_long     = thr_long_q;
    assign ui_len       = ui_len_q;
    assign dec_enable   = dec_enable_q;
    assign dec_restart  = (state_q == StCalc) && enable && ui_ok;
    assign audio_locked = audio_locked_q;
    assign lock_state   = state_q;
    assign relock_cnt   = relock_cnt_q;

endmodule

// File: tb/tb_spdif_lock_ctrl.sv
// Randomized scenario bench for spdif_lock_ctrl against a behavioural model of the lock rules.
module tb_spdif_lock_ctrl;

    localparam int AcqTo = 3000;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       enable = 1'b0;
    logic       edge_valid = 1'b0;
    logic [7:0] edge_len = 8'd0;
    logic       frame_sync = 1'b0;
    logic       code_err = 1'b0;
    logic [7:0] thr_short, thr_long, ui_len, relock_cnt;
    logic       dec_enable, dec_restart, audio_locked;
    logic [2:0] lock_state;

    int checks = 0;
    int errors = 0;
    int exp_ui = 0, exp_ts = 0, exp_tl = 0, exp_relock = 0;

    spdif_lock_ctrl #(
        .AcqTimeout(AcqTo)
    ) dut (
        .clk         (clk),
        .resetb      (resetb),
        .enable      (enable),
        .edge_valid  (edge_valid),
        .edge_len    (edge_len),
        .frame_sync  (frame_sync),
        .code_err    (code_err),
        .thr_short   (thr_short),
        .thr_long    (thr_long),
        .ui_len      (ui_len),
        .dec_enable  (dec_enable),
        .dec_restart (dec_restart),
        .audio_locked(audio_locked),
        .lock_state  (lock_state),
        .relock_cnt  (relock_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; outputs are read there too, half a cycle from posedge.
    task automatic drive(input logic ev, input logic [7:0] len, input logic fs, input logic ce);
        @(negedge clk);
        edge_valid = ev;
        edge_len   = len;
        frame_sync = fs;
        code_err   = ce;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (lock_state === s) begin
                ok = 1'b1;
                break;
            end
            drive(0, 8'd0, 0, 0);
        end
        if (lock_state === s) ok = 1'b1;
    endtask

    task automatic run_window(input int minv, input int maxv, output int got_min);
        int pos;
        int len;
        pos = $urandom_range(0, 255);
        got_min = 256;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 7) == 0) drive(1, 8'($urandom_range(0, 1)), 0, 0);
            if ($urandom_range(0, 1) == 0) drive(0, 8'd0, 0, 0);
            len = (i == pos) ? minv : $urandom_range(minv, maxv);
            if (len < got_min) got_min = len;
            if (i == 255) begin
                drive(0, 8'd0, 0, 0);
                drive(0, 8'd0, 0, 0);
                checks++;
                if (lock_state !== 3'd1) begin
                    errors++;
                    $display("FAIL window_early_exit: state %0d, expected 1", lock_state);
                end
            end
            drive(1, 8'(len), 0, 0);
        end
        drive(0, 8'd0, 0, 0);
    endtask

    // One full measurement window followed by the CALC decision.
    task automatic do_window(input int minv, input int maxv);
        int m;
        bit ok;
        bit valid;
        run_window(minv, maxv, m);
        wait_state(3'd2, 8, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL calc_reach: state %0d, expected 2", lock_state);
        end
        valid = (m >= 3) && (m <= 63);
        checks++;
        if (dec_restart !== valid) begin
            errors++;
            $display("FAIL calc_restart: got %0b expected %0b (min %0d)", dec_restart, valid, m);
        end
        drive(0, 8'd0, 0, 0);
        if (valid) begin
            exp_ui = m;
            exp_ts = (3 * m) / 2 > 255 ? 255 : (3 * m) / 2;
            exp_tl = (5 * m) / 2 > 255 ? 255 : (5 * m) / 2;
        end
        checks++;
        if (lock_state !== (valid ? 3'd3 : 3'd1)) begin
            errors++;
            $display("FAIL calc_next: state %0d expected %0d (min %0d)", lock_state,
                     valid ? 3 : 1, m);
        end
        checks++;
        if ({ui_len, thr_short, thr_long} !== {8'(exp_ui), 8'(exp_ts), 8'(exp_tl)}) begin
            errors++;
            $display("FAIL calc_cfg: ui/ts/tl %0d/%0d/%0d expected %0d/%0d/%0d", ui_len,
                     thr_short, thr_long, exp_ui, exp_ts, exp_tl);
        end
        checks++;
        if ({dec_enable, audio_locked} !== {valid, 1'b0}) begin
            errors++;
            $display("FAIL calc_flags: dec_en/locked %0b%0b expected %0b0", dec_enable,
                     audio_locked, valid);
        end
    endtask

    task automatic acquire_lock();
        bit ok;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'd0, 1, 0);
            drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 0, 0);
        end
        drive(0, 8'd0, 0, 0);
        drive(0, 8'd0, 0, 0);
        checks++;
        if ({lock_state, audio_locked} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL acq_three_syncs: state %0d locked %0b, expected 3/0", lock_state,
                     audio_locked);
        end
        drive(0, 8'd0, 1, 0);
        wait_state(3'd4, 6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lock_reach: state %0d, expected 4", lock_state);
        end
        checks++;
        if ({audio_locked, dec_enable} !== 2'b11) begin
            errors++;
            $display("FAIL lock_flags: locked/dec_en %0b%0b, expected 11", audio_locked,
                     dec_enable);
        end
    endtask

    task automatic test_reset();
        repeat (3) drive(0, 8'd0, 0, 0);
        checks++;
        if ({lock_state, audio_locked, dec_enable, dec_restart, ui_len, thr_short, thr_long,
             relock_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values: state %0d ui %0d ts %0d tl %0d relock %0d, expected 0",
                     lock_state, ui_len, thr_short, thr_long, relock_cnt);
        end
        resetb = 1'b1;
        drive(0, 8'd0, 0, 0);
        checks++;
        if (lock_state !== 3'd0) begin
            errors++;
            $display("FAIL idle_without_enable: state %0d, expected 0", lock_state);
        end
    endtask

    task automatic test_lock_ui8();
        enable = 1'b1;
        drive(0, 8'd0, 0, 0);
        checks++;
        if (lock_state !== 3'd1) begin
            errors++;
            $display("FAIL enable_to_measure: state %0d, expected 1", lock_state);
        end
        do_window(8, 24);
        checks++;
        if ({ui_len, thr_short, thr_long} !== {8'd8, 8'd12, 8'd20}) begin
            errors++;
            $display("FAIL ui8_cfg: %0d/%0d/%0d, expected 8/12/20", ui_len, thr_short, thr_long);
        end
        acquire_lock();
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({lock_state, audio_locked, dec_enable} !== {3'd0, 2'b00}) begin
            errors++;
            $display("FAIL enable_drop: state %0d locked %0b dec_en %0b, expected 0/0/0",
                     lock_state, audio_locked, dec_enable);
        end
        repeat (3) drive(0, 8'd0, 0, 0);
        checks++;
        if ({lock_state, relock_cnt, ui_len} !== {3'd0, 8'(exp_relock), 8'(exp_ui)}) begin
            errors++;
            $display("FAIL idle_hold: state %0d relock %0d ui %0d, expected 0/%0d/%0d",
                     lock_state, relock_cnt, ui_len, exp_relock, exp_ui);
        end
    endtask

    task automatic test_ui_bounds();
        int mins[5];
        mins[0] = 2;
        mins[1] = 3;
        mins[2] = 63;
        mins[3] = 64;
        mins[4] = $urandom_range(4, 62);
        for (int k = 0; k < 5; k++) begin
            enable = 1'b0;
            drive(0, 8'd0, 0, 0);
            enable = 1'b1;
            drive(0, 8'd0, 0, 0);
            checks++;
            if ({lock_state, dec_enable} !== {3'd1, 1'b0}) begin
                errors++;
                $display("FAIL bounds_restart: state %0d dec_en %0b, expected 1/0", lock_state,
                         dec_enable);
            end
            do_window(mins[k], mins[k] + $urandom_range(0, 100));
        end
    endtask

    task automatic test_bad_windows();
        enable = 1'b0;
        drive(0, 8'd0, 0, 0);
        enable = 1'b1;
        for (int i = 0; i < 300; i++) drive(1, 8'($urandom_range(0, 1)), 0, 0);
        repeat (3) drive(0, 8'd0, 0, 0);
        checks++;
        if ({lock_state, dec_enable, audio_locked} !== {3'd1, 2'b00}) begin
            errors++;
            $display("FAIL glitch_window: state %0d dec_en %0b locked %0b, expected 1/0/0",
                     lock_state, dec_enable, audio_locked);
        end
        do_window(80, 200);
    endtask

    task automatic test_err_leak();
        int  e;
        int  r;
        bit  fs;
        bit  ce;
        bit  ok;
        do_window(5, 15);
        acquire_lock();
        e = 0;
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (e >= 6) r = 7;
            fs = (r >= 5);
            ce = (r < 5) || (r >= 8);
            drive(0, 8'd0, fs, ce);
            drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 0, 0);
            if (ce && !fs) e++;
            else if (fs && !ce && e > 0) e--;
            checks++;
            if (lock_state !== 3'd4) begin
                errors++;
                $display("FAIL leak_random: state %0d expected 4 (model errs %0d)", lock_state, e);
            end
        end
        while (e < 7) begin
            drive(0, 8'd0, 0, 1);
            drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 0, 0);
            e++;
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 8'd0, 1, 1);
            drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 0, 0);
            checks++;
            if (lock_state !== 3'd4) begin
                errors++;
                $display("FAIL leak_both_same_cycle: state %0d, expected 4", lock_state);
            end
        end
        drive(0, 8'd0, 0, 1);
        drive(0, 8'd0, 0, 0);
        drive(0, 8'd0, 0, 0);
        exp_relock++;
        checks++;
        if ({lock_state, audio_locked, dec_enable} !== {3'd5, 2'b00}) begin
            errors++;
            $display("FAIL leak_drop: state %0d locked %0b dec_en %0b, expected 5/0/0",
                     lock_state, audio_locked, dec_enable);
        end
        checks++;
        if (relock_cnt !== 8'(exp_relock)) begin
            errors++;
            $display("FAIL relock_count_err: got %0d expected %0d", relock_cnt, exp_relock);
        end
        repeat (1000) drive(0, 8'd0, 0, 0);
        checks++;
        if (lock_state !== 3'd5) begin
            errors++;
            $display("FAIL holdoff_early_exit: state %0d, expected 5", lock_state);
        end
        wait_state(3'd1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL holdoff_to_measure: state %0d, expected 1", lock_state);
        end
        do_window(10, 30);
        acquire_lock();
    endtask

    task automatic test_sync_timeout();
        bit ok;
        for (int k = 0; k < 5; k++) begin
            repeat (1000) drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 1, 0);
            checks++;
            if (lock_state !== 3'd4) begin
                errors++;
                $display("FAIL sync_keepalive: state %0d, expected 4", lock_state);
            end
        end
        repeat (4080) drive(0, 8'd0, 0, 0);
        checks++;
        if (lock_state !== 3'd4) begin
            errors++;
            $display("FAIL sync_timeout_early: state %0d, expected 4", lock_state);
        end
        wait_state(3'd5, 40, ok);
        exp_relock++;
        checks++;
        if (!ok || relock_cnt !== 8'(exp_relock) || audio_locked !== 1'b0) begin
            errors++;
            $display("FAIL sync_timeout_drop: state %0d relock %0d locked %0b, expected 5/%0d/0",
                     lock_state, relock_cnt, audio_locked, exp_relock);
        end
        repeat (1000) drive(0, 8'd0, 0, 0);
        wait_state(3'd1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL holdoff2_to_measure: state %0d, expected 1", lock_state);
        end
    endtask

    task automatic test_acq_timeout();
        int u;
        bit ok;
        u = $urandom_range(3, 63);
        do_window(u, 3 * u);
        for (int g = 0; g < 160; g++) begin
            drive(0, 8'd0, 1, 0);
            repeat (5) drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 1, 0);
            repeat (5) drive(0, 8'd0, 0, 0);
            drive(0, 8'd0, 1, 1);
            repeat (5) drive(0, 8'd0, 0, 0);
            checks++;
            if (lock_state !== 3'd3) begin
                errors++;
                $display("FAIL acq_err_resets_sync: state %0d, expected 3 (group %0d)",
                         lock_state, g);
                break;
            end
        end
        wait_state(3'd1, 200, ok);
        checks++;
        if (!ok || dec_enable !== 1'b0) begin
            errors++;
            $display("FAIL acq_timeout: state %0d dec_en %0b, expected 1/0", lock_state,
                     dec_enable);
        end
        do_window(u, 3 * u);
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        drive(0, 8'd0, 0, 0);
        enable = 1'b1;
        drive(0, 8'd0, 0, 0);
        for (int i = 0; i < 100; i++) drive(1, 8'($urandom_range(5, 20)), 0, 0);
        drive(0, 8'd0, 0, 0);
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ({lock_state, audio_locked, dec_enable, dec_restart, ui_len, thr_short, thr_long,
             relock_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: state %0d ui %0d ts %0d tl %0d relock %0d, expected 0",
                     lock_state, ui_len, thr_short, thr_long, relock_cnt);
        end
        @(negedge clk);
        resetb = 1'b1;
        exp_ui = 0;
        exp_ts = 0;
        exp_tl = 0;
        exp_relock = 0;
        drive(0, 8'd0, 0, 0);
        checks++;
        if (lock_state !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_measure: state %0d, expected 1", lock_state);
        end
        do_window(6, 20);
        acquire_lock();
    endtask

    initial begin
        test_reset();
        test_lock_ui8();
        test_enable_drop();
        test_ui_bounds();
        test_bad_windows();
        test_err_leak();
        test_sync_timeout();
        test_acq_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
